// File: rtl/mult_share_arbiter_if.sv
// Operand request and tagged response bundle between requester blocks and mult_share_arbiter.
interface mult_share_arbiter_if #(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned WIDTH = 8,
    parameter int unsigned ID_W  = 2
) ();
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic                  resp_valid;
    logic                  resp_ready;
    logic [ID_W-1:0]       resp_id;
    logic [2*WIDTH-1:0]    resp_product;

    modport master (
        output req_valid, req_a, req_b, resp_ready,
        input  req_ready, resp_valid, resp_id, resp_product
    );

    modport slave (
        input  req_valid, req_a, req_b, resp_ready,
        output req_ready, resp_valid, resp_id, resp_product
    );
endinterface

// File: rtl/mult_share_arbiter.sv
// Round-robin sequencer sharing one combinational multiplier among NREQ requesters,
// one operation in flight, tagged responses on a single valid/ready port.
module mult_share_arbiter #(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned WIDTH = 8,
    parameter int unsigned ID_W  = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    mult_share_arbiter_if.slave  bus,
    output logic [WIDTH-1:0]     mul_a,
    output logic [WIDTH-1:0]     mul_b,
    input  logic [2*WIDTH-1:0]   mul_product,
    output logic                 busy,
    output logic [15:0]          op_count
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] MUL  = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]         state_q;
    logic [ID_W-1:0]    rr_ptr_q;
    logic [ID_W-1:0]    tag_q;
    logic [WIDTH-1:0]   mul_a_q;
    logic [WIDTH-1:0]   mul_b_q;
    logic               resp_valid_q;
    logic [ID_W-1:0]    resp_id_q;
    logic [2*WIDTH-1:0] resp_product_q;
    logic [15:0]        op_count_q;

    logic               grant_found;
    logic [ID_W-1:0]    grant_idx;
    logic [ID_W:0]      scan_idx;
    logic [WIDTH-1:0]   sel_a;
    logic [WIDTH-1:0]   sel_b;
    logic [ID_W-1:0]    rr_ptr_next;

    // Scan rr_ptr, rr_ptr+1, ... (mod NREQ); first valid requester wins.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        scan_idx    = '0;
        for (int k = 0; k < NREQ; k++) begin
            scan_idx = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
            if (scan_idx >= (ID_W+1)'(NREQ)) begin
                scan_idx = scan_idx - (ID_W+1)'(NREQ);
            end
            if (!grant_found && bus.req_valid[scan_idx[ID_W-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = scan_idx[ID_W-1:0];
            end
        end
    end

    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_idx == ID_W'(i)) begin
                sel_a = bus.req_a[i*WIDTH +: WIDTH];
                sel_b = bus.req_b[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        bus.req_ready = '0;
        if (state_q == IDLE && grant_found) begin
            bus.req_ready[grant_idx] = 1'b1;
        end
    end

    // Last-served requester drops to lowest priority.
    assign rr_ptr_next = (resp_id_q == ID_W'(NREQ - 1)) ? '0 : resp_id_q + 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            rr_ptr_q       <= '0;
            tag_q          <= '0;
            mul_a_q        <= '0;
            mul_b_q        <= '0;
            resp_valid_q   <= 1'b0;
            resp_id_q      <= '0;
            resp_product_q <= '0;
            op_count_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant_found) begin
                        mul_a_q <= sel_a;
                        mul_b_q <= sel_b;
                        tag_q   <= grant_idx;
                        state_q <= MUL;
                    end
                end
                MUL: begin
                    resp_product_q <= mul_product;
                    resp_id_q      <= tag_q;
                    resp_valid_q   <= 1'b1;
                    state_q        <= RESP;
                end
                RESP: begin
                    if (bus.resp_ready) begin
                        resp_valid_q <= 1'b0;
                        op_count_q   <= op_count_q + 16'd1;
                        rr_ptr_q     <= rr_ptr_next;
                        state_q      <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.resp_valid   = resp_valid_q;
    assign bus.resp_id      = resp_id_q;
    assign bus.resp_product = resp_product_q;
    assign mul_a            = mul_a_q;
    assign mul_b            = mul_b_q;
    assign busy             = (state_q != IDLE);
    assign op_count         = op_count_q;

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Directed self-checking bench for mult_share_arbiter with a behavioural multiplier.
module tb_mult_share_arbiter;

    localparam int unsigned NREQ  = 4;
    localparam int unsigned WIDTH = 8;
    localparam int unsigned ID_W  = 2;

    logic        clk;
    logic        reset;
    logic [7:0]  mul_a;
    logic [7:0]  mul_b;
    logic [15:0] mul_product;
    logic        busy;
    logic [15:0] op_count;

    int tests;
    int fails;

    mult_share_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH), .ID_W(ID_W)) bus ();

    mult_share_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .ID_W(ID_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus.slave),
        .mul_a       (mul_a),
        .mul_b       (mul_b),
        .mul_product (mul_product),
        .busy        (busy),
        .op_count    (op_count)
    );

    assign mul_product = 16'(mul_a) * 16'(mul_b);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        tests            = 0;
        fails            = 0;
        reset            = 1'b1;
        bus.req_valid    = '0;
        bus.req_a        = '0;
        bus.req_b        = '0;
        bus.resp_ready   = 1'b0;
        step();
        step();
        chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_op_count", 32'(op_count), 32'd0);
        chk("rst_mul_a", 32'(mul_a), 32'd0);
        chk("rst_resp_product", 32'(bus.resp_product), 32'd0);
        chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
        reset = 1'b0;
        step();
        chk("idle_no_req_ready", 32'(bus.req_ready), 32'd0);

        // Single request from requester 0
        bus.req_a[7:0]  = 8'd3;
        bus.req_b[7:0]  = 8'd5;
        bus.req_valid   = 4'b0001;
        bus.resp_ready  = 1'b1;
        #1;
        chk("t1_ready", 32'(bus.req_ready), 32'h1);
        step();
        bus.req_valid = '0;
        chk("t1_mul_ready0", 32'(bus.req_ready), 32'd0);
        chk("t1_busy", 32'(busy), 32'd1);
        chk("t1_mul_a", 32'(mul_a), 32'd3);
        chk("t1_no_resp_yet", 32'(bus.resp_valid), 32'd0);
        step();
        chk("t1_resp_valid", 32'(bus.resp_valid), 32'd1);
        chk("t1_resp_id", 32'(bus.resp_id), 32'd0);
        chk("t1_product", 32'(bus.resp_product), 32'd15);
        step();
        chk("t1_done_valid", 32'(bus.resp_valid), 32'd0);
        chk("t1_op_count", 32'(op_count), 32'd1);
        chk("t1_idle", 32'(busy), 32'd0);

        // Full-width product from requester 3 (rr_ptr now 1)
        bus.req_a[31:24] = 8'd255;
        bus.req_b[31:24] = 8'd255;
        bus.req_valid    = 4'b1000;
        #1;
        chk("t3_ready", 32'(bus.req_ready), 32'h8);
        step();
        bus.req_valid = '0;
        step();
        chk("t3_id", 32'(bus.resp_id), 32'd3);
        chk("t3_product", 32'(bus.resp_product), 32'hFE01);
        step();
        chk("t3_op_count", 32'(op_count), 32'd2);

        // All requesters valid continuously; rr_ptr is back to 0
        for (int i = 0; i < 4; i++) begin
            bus.req_a[i*8 +: 8] = 8'(i + 1);
            bus.req_b[i*8 +: 8] = 8'd10;
        end
        bus.req_valid = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            #1;
            chk("t2_grant", 32'(bus.req_ready), 32'(1) << (n % 4));
            step();
            step();
            chk("t2_resp_ready0", 32'(bus.req_ready), 32'd0);
            chk("t2_id", 32'(bus.resp_id), 32'(n % 4));
            chk("t2_product", 32'(bus.resp_product), 32'(((n % 4) + 1) * 10));
            step();
            chk("t2_op_count", 32'(op_count), 32'(3 + n));
        end
        bus.req_valid = '0;

        // Back-pressure in RESP; rr_ptr is 1
        bus.req_a[7:0] = 8'd7;
        bus.req_b[7:0] = 8'd6;
        bus.req_valid  = 4'b0001;
        bus.resp_ready = 1'b0;
        #1;
        chk("t4_ready", 32'(bus.req_ready), 32'h1);
        step();
        bus.req_valid = 4'b1111;
        step();
        for (int c = 0; c < 5; c++) begin
            chk("t4_hold_valid", 32'(bus.resp_valid), 32'd1);
            chk("t4_hold_id", 32'(bus.resp_id), 32'd0);
            chk("t4_hold_product", 32'(bus.resp_product), 32'd42);
            chk("t4_hold_busy", 32'(busy), 32'd1);
            chk("t4_hold_ready0", 32'(bus.req_ready), 32'd0);
            step();
        end
        chk("t4_count_held", 32'(op_count), 32'd7);
        bus.req_valid  = '0;
        bus.resp_ready = 1'b1;
        step();
        chk("t4_done_valid", 32'(bus.resp_valid), 32'd0);
        chk("t4_op_count", 32'(op_count), 32'd8);

        // Serve requester 1, then 2 and 1 compete: 2 must win
        bus.req_a[15:8] = 8'd4;
        bus.req_b[15:8] = 8'd4;
        bus.req_valid   = 4'b0010;
        #1;
        chk("t6_r1_ready", 32'(bus.req_ready), 32'h2);
        step();
        bus.req_valid = '0;
        step();
        step();
        bus.req_a[23:16] = 8'd9;
        bus.req_b[23:16] = 8'd9;
        bus.req_valid    = 4'b0110;
        #1;
        chk("t6_r2_wins", 32'(bus.req_ready), 32'h4);
        step();
        bus.req_valid = 4'b0010;
        step();
        chk("t6_r2_id", 32'(bus.resp_id), 32'd2);
        chk("t6_r2_product", 32'(bus.resp_product), 32'd81);
        step();
        #1;
        chk("t6_r1_next", 32'(bus.req_ready), 32'h2);
        step();
        bus.req_valid = '0;
        step();
        chk("t6_r1_id", 32'(bus.resp_id), 32'd1);
        chk("t6_r1_product", 32'(bus.resp_product), 32'd16);
        step();
        chk("t6_op_count", 32'(op_count), 32'd11);

        // Requester 3 raises then drops valid while busy: never served
        bus.req_valid = 4'b0001;
        step();
        bus.req_valid = 4'b1000;
        step();
        bus.req_valid = '0;
        step();
        chk("t6_drop_ready0", 32'(bus.req_ready), 32'd0);
        step();
        chk("t6_drop_idle", 32'(busy), 32'd0);
        chk("t6_drop_count", 32'(op_count), 32'd12);

        // Reset during MUL drops the in-flight op
        bus.req_valid = 4'b0001;
        step();
        bus.req_valid = '0;
        chk("t5_in_mul", 32'(busy), 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("t5_no_resp", 32'(bus.resp_valid), 32'd0);
        chk("t5_idle", 32'(busy), 32'd0);
        chk("t5_op_count", 32'(op_count), 32'd0);
        step();
        chk("t5_still_no_resp", 32'(bus.resp_valid), 32'd0);
        bus.req_valid = 4'b1111;
        #1;
        chk("t5_rr_ptr0", 32'(bus.req_ready), 32'h1);
        bus.req_valid = '0;
        step();
        chk("t5_stay_idle", 32'(busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
